// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC job scheduler: mode encodings,
// scheduler states and status bit positions for the register map.
package cordic_pkg;

    localparam logic [1:0] CIRCULAR   = 2'd0;
    localparam logic [1:0] LINEAR     = 2'd1;
    localparam logic [1:0] HYPERBOLIC = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam int unsigned STAT_BUSY      = 0;
    localparam int unsigned STAT_CMD_READY = 1;
    localparam int unsigned STAT_RES_VALID = 2;
    localparam int unsigned STAT_RES_ERR   = 3;
    localparam int unsigned STAT_TIMEOUT   = 4;

    function automatic logic is_reserved(input logic [1:0] mode);
        return mode == MODE_RSVD;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output; flush empties it
// and takes priority over a push in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_cnt;
    logic [AW:0]      rd_cnt;
    logic             do_push;
    logic             do_pop;

    assign level   = wr_cnt - rd_cnt;
    assign empty   = (wr_cnt == rd_cnt);
    assign full    = (level == CAP);
    assign do_pop  = pop && !empty;
    // A pop frees the slot, so a full FIFO still accepts a simultaneous push.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_cnt[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (do_push) wr_cnt <= wr_cnt + 1'b1;
            if (do_pop)  rd_cnt <= rd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wr_cnt[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cordic_job_scheduler.sv
// Queues CORDIC jobs, issues them one at a time to the shared core and collects
// tagged results; a watchdog converts a hung job into an error result.
module cordic_job_scheduler
    import cordic_pkg::*;
#(
    parameter int unsigned FIXED_WIDTH = 16,
    parameter int unsigned SHIFT_W     = 4,
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_mode,
    input  logic                     cmd_rotating,
    input  logic [SHIFT_W-1:0]       cmd_shift,
    input  logic [FIXED_WIDTH-1:0]   cmd_a,
    input  logic [FIXED_WIDTH-1:0]   cmd_b,
    input  logic [TAG_W-1:0]         cmd_tag,
    output logic                     cor_start,
    output logic [1:0]               cor_mode,
    output logic                     cor_rotating,
    output logic [SHIFT_W-1:0]       cor_shift,
    output logic [FIXED_WIDTH-1:0]   cor_a,
    output logic [FIXED_WIDTH-1:0]   cor_b,
    input  logic [FIXED_WIDTH-1:0]   cor_out1,
    input  logic [FIXED_WIDTH-1:0]   cor_out2,
    input  logic                     cor_done,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [FIXED_WIDTH-1:0]   res_out1,
    output logic [FIXED_WIDTH-1:0]   res_out2,
    output logic [TAG_W-1:0]         res_tag,
    output logic                     res_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   cmd_level,
    output logic [$clog2(DEPTH):0]   res_level,
    output logic                     irq,
    output logic                     timeout_seen
);

    localparam int unsigned CMD_W = 2 + 1 + SHIFT_W + 2 * FIXED_WIDTH + TAG_W;
    localparam int unsigned RES_W = 2 * FIXED_WIDTH + TAG_W + 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t state;
    state_t state_next;

    logic [CMD_W-1:0]       cmd_wdata;
    logic [CMD_W-1:0]       cmd_rdata;
    logic                   cmd_full;
    logic                   cmd_empty;
    logic                   cmd_pop;

    logic [1:0]             head_mode;
    logic                   head_rotating;
    logic [SHIFT_W-1:0]     head_shift;
    logic [FIXED_WIDTH-1:0] head_a;
    logic [FIXED_WIDTH-1:0] head_b;
    logic [TAG_W-1:0]       head_tag;

    logic [TAG_W-1:0]       job_tag;
    logic [WD_W-1:0]        wd_cnt;

    logic [RES_W-1:0]       res_wdata;
    logic [RES_W-1:0]       res_rdata;
    logic                   res_full;
    logic                   res_empty;
    logic                   res_push;
    logic [FIXED_WIDTH-1:0] push_out1;
    logic [FIXED_WIDTH-1:0] push_out2;
    logic                   push_err;
    logic                   timeout_hit;

    assign cmd_ready = !cmd_full;
    assign cmd_wdata = {cmd_mode, cmd_rotating, cmd_shift, cmd_a, cmd_b, cmd_tag};
    assign {head_mode, head_rotating, head_shift, head_a, head_b, head_tag} = cmd_rdata;

    sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (cmd_valid && cmd_ready),
        .wdata (cmd_wdata),
        .pop   (cmd_pop),
        .rdata (cmd_rdata),
        .full  (cmd_full),
        .empty (cmd_empty),
        .level (cmd_level)
    );

    assign res_wdata = {push_out1, push_out2, job_tag, push_err};
    assign {res_out1, res_out2, res_tag, res_err} = res_rdata;
    assign res_valid = !res_empty;

    sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (res_push),
        .wdata (res_wdata),
        .pop   (res_ready),
        .rdata (res_rdata),
        .full  (res_full),
        .empty (res_empty),
        .level (res_level)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A job is only taken when its result slot is guaranteed, since one job at most is in flight.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (!cmd_empty && !res_full) state_next = ISSUE;
            ISSUE:   state_next = is_reserved(cor_mode) ? IDLE : WAIT;
            WAIT:    if (cor_done || wd_cnt == WD_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_pop     = 1'b0;
        cor_start   = 1'b0;
        res_push    = 1'b0;
        push_out1   = '0;
        push_out2   = '0;
        push_err    = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: cmd_pop = !cmd_empty && !res_full;
            ISSUE: begin
                if (is_reserved(cor_mode)) begin
                    res_push = 1'b1;
                    push_err = 1'b1;
                end else begin
                    cor_start = 1'b1;
                end
            end
            WAIT: begin
                if (cor_done) begin
                    res_push  = 1'b1;
                    push_out1 = cor_out1;
                    push_out2 = cor_out2;
                end else if (wd_cnt == WD_LAST) begin
                    res_push    = 1'b1;
                    push_err    = 1'b1;
                    timeout_hit = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign irq  = res_push;
    assign busy = (state != IDLE) || !cmd_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            cor_mode     <= '0;
            cor_rotating <= 1'b0;
            cor_shift    <= '0;
            cor_a        <= '0;
            cor_b        <= '0;
            job_tag      <= '0;
        end else if (cmd_pop) begin
            cor_mode     <= head_mode;
            cor_rotating <= head_rotating;
            cor_shift    <= head_shift;
            cor_a        <= head_a;
            cor_b        <= head_b;
            job_tag      <= head_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                 wd_cnt <= '0;
        else if (state == ISSUE) wd_cnt <= '0;
        else if (state == WAIT)  wd_cnt <= wd_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || flush)     timeout_seen <= 1'b0;
        else if (timeout_hit) timeout_seen <= 1'b1;
    end

endmodule
